// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit serializer: FSM states, default word width
// and the counter-width helper.
package bit_serializer_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StShift = 1'b1
    } state_e;

    // Bits needed to count 0..value-1, never less than one.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word holding register so that
// consecutive words stream out with no idle cycle between them.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = DefaultWidth,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             ser_last
);

    localparam int unsigned      CntW    = clog2(WIDTH);
    localparam logic [CntW-1:0]  LastCnt = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hold_data_q, hold_data_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             ser_bit_q, ser_bit_d;
    logic             ser_valid_q, ser_valid_d;
    logic             ser_last_q, ser_last_d;

    logic accept;
    logic last_bit;
    logic load;
    logic cur_bit;

    // Ready depends only on the holding register, never on in_valid.
    assign in_ready = ~hold_full_q;
    assign accept   = in_valid & ~hold_full_q;
    assign last_bit = (state_q == StShift) && (cnt_q == LastCnt);
    // A held word enters the shifter when idle or right as the final bit goes out.
    assign load     = hold_full_q & ((state_q == StIdle) | last_bit);
    assign cur_bit  = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

    // Next-state logic for holding register, shifter, counter and outputs.
    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        hold_full_d = hold_full_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;

        // accept and load are mutually exclusive: one needs hold empty, the other full.
        if (accept) begin
            hold_data_d = in_data;
            hold_full_d = 1'b1;
        end

        if (load) begin
            shreg_d     = hold_data_q;
            cnt_d       = '0;
            hold_full_d = 1'b0;
            state_d     = StShift;
        end else if (state_q == StShift) begin
            if (last_bit) begin
                cnt_d   = '0;
                state_d = StIdle;
            end else begin
                cnt_d   = cnt_q + CntW'(1);
                shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
            end
        end

        // Outputs lag the shifter by one register stage.
        ser_valid_d = (state_q == StShift);
        ser_bit_d   = (state_q == StShift) ? cur_bit : IDLE_BIT;
        ser_last_d  = last_bit;
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            hold_data_q <= '0;
            hold_full_q <= 1'b0;
            shreg_q     <= '0;
            cnt_q       <= '0;
            ser_bit_q   <= IDLE_BIT;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_full_q <= hold_full_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            ser_bit_q   <= ser_bit_d;
            ser_valid_q <= ser_valid_d;
            ser_last_q  <= ser_last_d;
        end
    end

    assign ser_bit   = ser_bit_q;
    assign ser_valid = ser_valid_q;
    assign ser_last  = ser_last_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench: instance 0 is MSB-first with idle 0, instance 1 is
// LSB-first with idle 1. Expected bits and their cycle are derived from
// accept times and the previous word's end time.
module tb_bit_serializer;

    localparam int unsigned W = 8;

    typedef struct {
        int cyc;
        bit b;
        bit last;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_data   [2];
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic         ser_bit   [2];
    logic         ser_valid [2];
    logic         ser_last  [2];

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic bit exp_bit(input logic [W-1:0] w, input int i, input bit msb);
        return msb ? w[W-1-i] : w[i];
    endfunction

    // First bit two cycles after accept, or straight after the previous word.
    function automatic int start_of(input int t, input int le);
        return (t + 2 > le + 1) ? t + 2 : le + 1;
    endfunction

    // Non-overlapping count of the pattern 1,0,1,0.
    function automatic int count_1010(input bit s[$]);
        int n = 0;
        int i = 0;
        while (i + 3 < s.size()) begin
            if (s[i] && !s[i+1] && s[i+2] && !s[i+3]) begin
                n++;
                i += 4;
            end else begin
                i++;
            end
        end
        return n;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam bit Msb  = (gi == 0);
        localparam bit Idle = (gi == 1);

        exp_t exp_q[$];
        bit   obs_q[$];
        int   last_end = 0;
        int   acc_edge = -1;

        bit_serializer #(
            .WIDTH    (W),
            .MSB_FIRST(Msb),
            .IDLE_BIT (Idle)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .in_data  (in_data[gi]),
            .in_valid (in_valid[gi]),
            .in_ready (in_ready[gi]),
            .ser_bit  (ser_bit[gi]),
            .ser_valid(ser_valid[gi]),
            .ser_last (ser_last[gi])
        );

        // Stimulus side: every accepted word becomes W timed expected bits.
        always @(posedge clk) begin
            if (!reset) begin
                exp_q.delete();
                last_end <= 0;
            end else if (in_valid[gi] && in_ready[gi]) begin
                for (int i = 0; i < W; i++) begin
                    exp_q.push_back(exp_t'{start_of(edge_n + 1, last_end) + i,
                                           exp_bit(in_data[gi], i, Msb), (i == W - 1)});
                end
                last_end <= start_of(edge_n + 1, last_end) + W - 1;
                acc_edge <= edge_n + 1;
            end
        end

        // Monitor side: compare what the DUT presents against the queue head.
        always @(negedge clk) begin
            if (!reset) begin
                chk(ser_valid[gi] == 1'b0, "reset_valid", ser_valid[gi], 0);
                chk(ser_last[gi] == 1'b0, "reset_last", ser_last[gi], 0);
                chk(ser_bit[gi] == Idle, "reset_bit", ser_bit[gi], Idle);
            end else begin
                if (acc_edge == edge_n) begin
                    chk(in_ready[gi] == 1'b0, "ready_low_when_held", in_ready[gi], 0);
                end
                if (ser_valid[gi]) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_bit", 1, 0);
                    end else begin
                        chk(edge_n == exp_q[0].cyc, "bit_cycle", edge_n, exp_q[0].cyc);
                        chk(ser_bit[gi] == exp_q[0].b, "bit_value", ser_bit[gi], exp_q[0].b);
                        chk(ser_last[gi] == exp_q[0].last, "bit_last", ser_last[gi],
                            exp_q[0].last);
                        exp_q.delete(0);
                    end
                    obs_q.push_back(ser_bit[gi]);
                end else begin
                    chk(ser_bit[gi] == Idle, "idle_bit", ser_bit[gi], Idle);
                    chk(ser_last[gi] == 1'b0, "idle_last", ser_last[gi], 0);
                    if (exp_q.size() != 0 && exp_q[0].cyc <= edge_n) begin
                        chk(1'b0, "missing_bit", 0, 1);
                        exp_q.delete(0);
                    end
                end
            end
        end
    end

    // Hold in_valid with stable data until accepted, then scramble in_data.
    task automatic send(input int idx, input logic [W-1:0] w);
        int guard = 0;
        @(negedge clk);
        in_valid[idx] = 1'b1;
        in_data[idx]  = w;
        while (!in_ready[idx] && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk(in_ready[idx] == 1'b1, "accept_timeout", guard, 0);
        @(posedge clk);
        #1;
        in_valid[idx] = 1'b0;
        in_data[idx]  = 8'($urandom);
    endtask

    task automatic drain();
        int guard = 0;
        while ((g_dut[0].exp_q.size() != 0 || g_dut[1].exp_q.size() != 0) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk(g_dut[0].exp_q.size() == 0, "drain0", g_dut[0].exp_q.size(), 0);
        chk(g_dut[1].exp_q.size() == 0, "drain1", g_dut[1].exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic rand_run(input int idx);
        repeat (20) begin
            repeat ($urandom_range(0, 12)) @(negedge clk);
            send(idx, 8'($urandom));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit model_bits[$];
        bit seen[$];
        int mark;

        reset       = 1'b0;
        in_valid[0] = 1'b0;
        in_valid[1] = 1'b0;
        in_data[0]  = '0;
        in_data[1]  = '0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk(in_ready[0] == 1'b1, "ready_after_reset0", in_ready[0], 1);
        chk(in_ready[1] == 1'b1, "ready_after_reset1", in_ready[1], 1);

        // Single word each: 0xA5 MSB-first, 0x05 LSB-first.
        fork
            send(0, 8'hA5);
            send(1, 8'h05);
        join
        drain();

        // Back-to-back pair, then a third word stalled behind a full holding register.
        send(0, 8'hA0);
        send(0, 8'h0A);
        drain();
        send(0, 8'h11);
        send(0, 8'h22);
        send(0, 8'h3C);
        drain();

        // 1010 detector on the serial stream of 0xAA, 0xAA.
        mark = g_dut[0].obs_q.size();
        send(0, 8'hAA);
        send(0, 8'hAA);
        drain();
        for (int i = mark; i < g_dut[0].obs_q.size(); i++) seen.push_back(g_dut[0].obs_q[i]);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < W; i++) model_bits.push_back(exp_bit(8'hAA, i, 1'b1));
        end
        chk(count_1010(seen) == count_1010(model_bits), "detector_count", count_1010(seen),
            count_1010(model_bits));
        chk(count_1010(seen) == 4, "detector_golden", count_1010(seen), 4);

        fork
            rand_run(0);
            rand_run(1);
        join
        drain();

        // Reset at the 4th bit of 0xFF with 0x12 waiting in the holding register.
        send(0, 8'hFF);
        send(0, 8'h12);
        @(negedge clk);
        repeat (3) @(negedge clk);
        chk(ser_valid[0] == 1'b1, "mid_word_before_reset", ser_valid[0], 1);
        #1 reset = 1'b0;
        #1;
        chk(ser_valid[0] == 1'b0, "async_reset_valid", ser_valid[0], 0);
        chk(ser_last[0] == 1'b0, "async_reset_last", ser_last[0], 0);
        chk(ser_bit[0] == 1'b0, "async_reset_bit", ser_bit[0], 0);
        chk(in_ready[0] == 1'b1, "async_reset_ready", in_ready[0], 1);
        @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (12) @(negedge clk);
        chk(ser_valid[0] == 1'b0, "no_bits_after_reset", ser_valid[0], 0);
        send(0, 8'h5A);
        drain();

        chk(g_dut[0].exp_q.size() == 0, "final_empty0", g_dut[0].exp_q.size(), 0);
        chk(g_dut[1].exp_q.size() == 0, "final_empty1", g_dut[1].exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
